// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, reset PC and fetch queue entry type
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_W = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory, redirect and decode handshakes of the fetch stage
interface fetch_stage_if;
   logic                          imem_req_valid;
   logic [riscv_pkg::XLEN-1:0]    imem_req_addr;
   logic                          imem_req_ready;
   logic                          imem_rsp_valid;
   logic [riscv_pkg::INSTR_W-1:0] imem_rsp_data;
   logic                          redirect;
   logic [riscv_pkg::XLEN-1:0]    redirect_pc;
   logic                          id_valid;
   logic [riscv_pkg::INSTR_W-1:0] id_instr;
   logic [riscv_pkg::XLEN-1:0]    id_pc;
   logic                          id_ready;
   modport master (
      output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two registered FIFO with flush, used for PC tags and the fetch queue
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rd_ptr];
   // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
   always_ff @(posedge clk)
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   // Storage write; contents need no reset since occupancy gates their use
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing instruction reads, buffering responses and handling redirects
module fetch_stage import riscv_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int QDEPTH = 2
) (
   input logic clk,
   input logic rst,
   fetch_stage_if.master bus
);
   localparam int CW = $clog2(QDEPTH) + 1;
   logic [XLEN-1:0] pc, tag_pc;
   logic [CW-1:0] inflight, drop, q_count, tag_count;
   logic [CW+1:0] occ;
   logic hs, rsp_keep, pop, q_full, q_empty, tag_full, tag_empty;
   fetch_entry_t q_in, head;
   assign occ = (CW+2)'(inflight) + (CW+2)'(drop) + (CW+2)'(q_count);
   assign hs = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_keep = bus.imem_rsp_valid && drop == '0;
   assign pop = bus.id_valid && bus.id_ready && !bus.redirect;
   assign q_in = '{pc: tag_pc, instr: bus.imem_rsp_data};
   assign bus.imem_req_valid = !rst && !bus.redirect && occ < (CW+2)'(QDEPTH);
   assign bus.imem_req_addr = pc;
   assign bus.id_valid = !rst && !q_empty;
   assign bus.id_pc = head.pc;
   assign bus.id_instr = bus.id_valid ? head.instr : NOP_INSTR;
   fetch_fifo #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_tag_fifo (
      .clk(clk), .rst(rst), .push(hs), .pop(rsp_keep), .flush(bus.redirect),
      .din(pc), .dout(tag_pc), .full(tag_full), .empty(tag_empty), .count(tag_count)
   );
   fetch_fifo #(.DEPTH(QDEPTH), .WIDTH($bits(fetch_entry_t))) u_queue (
      .clk(clk), .rst(rst), .push(rsp_keep && !bus.redirect), .pop(pop), .flush(bus.redirect),
      .din(q_in), .dout(head), .full(q_full), .empty(q_empty), .count(q_count)
   );
   // PC and outstanding-request counters; redirect turns every live request into a drop
   always_ff @(posedge clk)
      if (rst) begin
         pc <= RESET_PC;
         inflight <= '0;
         drop <= '0;
      end else if (bus.redirect) begin
         pc <= bus.redirect_pc & ~32'd3;
         inflight <= '0;
         drop <= drop + inflight - CW'(bus.imem_rsp_valid);
      end else begin
         pc <= hs ? pc + 32'd4 : pc;
         inflight <= inflight + CW'(hs) - CW'(rsp_keep);
         drop <= drop - CW'(bus.imem_rsp_valid && drop != '0);
      end
   // Memory protocol and tag bookkeeping invariants
   always_ff @(posedge clk)
      if (!rst) begin
         assert (!(bus.imem_rsp_valid && q_full));
         assert (!(rsp_keep && tag_empty));
         assert (!(hs && tag_full));
         assert (tag_count == inflight);
      end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with an in-order variable-latency memory model
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] pend_addr[$];
   int pend_due[$];
   logic [31:0] req_log[$];
   logic [63:0] got[$];
   fetch_stage_if bus();
   fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   function automatic logic [63:0] ent(input logic [31:0] a);
      return {a, instr_of(a)};
   endfunction
   function automatic logic [63:0] got_at(input int i);
      return (i < got.size()) ? got[i] : {64{1'b1}};
   endfunction
   function automatic logic [63:0] req_at(input int i);
      return (i < req_log.size()) ? {32'h0, req_log[i]} : {64{1'b1}};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock cycle: sample handshakes, clock edge, memory model drives next-cycle response
   task automatic tick();
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         pend_addr.push_back(bus.imem_req_addr);
         pend_due.push_back(cyc + lat);
         req_log.push_back(bus.imem_req_addr);
      end
      if (bus.id_valid && bus.id_ready && !bus.redirect) got.push_back({bus.id_pc, bus.id_instr});
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data = instr_of(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data = 32'h0;
      end
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      ticks(2);
      rst = 1'b0;
      req_log.delete();
      got.delete();
   endtask

   initial begin
      rst = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'h0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.id_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
      chk("rst_id_valid", {63'h0, bus.id_valid}, 64'h0);

      // streaming with one-cycle memory latency
      lat = 1;
      do_reset();
      #1;
      chk("a_first_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      chk("a_first_addr", {32'h0, bus.imem_req_addr}, 64'h0);
      tick();
      chk("a_no_bypass", {63'h0, bus.id_valid}, 64'h0);
      tick();
      chk("a_head_valid", {63'h0, bus.id_valid}, 64'h1);
      chk("a_head", {bus.id_pc, bus.id_instr}, ent(32'h0));
      ticks(10);
      for (int i = 0; i < 4; i++) chk($sformatf("a_req%0d", i), req_at(i), {32'h0, 32'(4 * i)});
      for (int i = 0; i < 3; i++) chk($sformatf("a_id%0d", i), got_at(i), ent(32'(4 * i)));

      // decode back-pressure
      bus.id_ready = 1'b0;
      do_reset();
      ticks(10);
      chk("b_req_count", {32'h0, 32'(req_log.size())}, 64'd2);
      chk("b_head_valid", {63'h0, bus.id_valid}, 64'h1);
      chk("b_head", {bus.id_pc, bus.id_instr}, ent(32'h0));
      bus.id_ready = 1'b1;
      ticks(14);
      for (int i = 0; i < 4; i++) chk($sformatf("b_id%0d", i), got_at(i), ent(32'(4 * i)));

      // memory stall holds the address
      bus.imem_req_ready = 1'b0;
      do_reset();
      ticks(5);
      chk("c_held_addr", {32'h0, bus.imem_req_addr}, 64'h0);
      chk("c_held_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      bus.imem_req_ready = 1'b1;
      tick();
      chk("c_first_hs", req_at(0), 64'h0);
      chk("c_next_addr", {32'h0, bus.imem_req_addr}, 64'h4);

      // redirect with two requests in flight
      lat = 3;
      do_reset();
      ticks(2);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0100;
      #1;
      chk("d_no_req_redirect", {63'h0, bus.imem_req_valid}, 64'h0);
      tick();
      bus.redirect = 1'b0;
      req_log.delete();
      got.delete();
      #1;
      chk("d_drop_credit", {63'h0, bus.imem_req_valid}, 64'h0);
      ticks(8);
      chk("d_req0", req_at(0), 64'h100);
      chk("d_id0", got_at(0), ent(32'h100));

      // redirect coinciding with a response and a pop, misaligned target
      lat = 1;
      do_reset();
      ticks(2);
      chk("e_head_before", {bus.id_pc, bus.id_instr}, ent(32'h0));
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0203;
      #1;
      chk("e_no_req_redirect", {63'h0, bus.imem_req_valid}, 64'h0);
      tick();
      bus.redirect = 1'b0;
      req_log.delete();
      got.delete();
      #1;
      chk("e_id_flushed", {63'h0, bus.id_valid}, 64'h0);
      chk("e_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      chk("e_req_addr", {32'h0, bus.imem_req_addr}, 64'h200);
      ticks(4);
      chk("e_id0", got_at(0), ent(32'h200));

      // PC wrap
      do_reset();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      tick();
      bus.redirect = 1'b0;
      #1;
      chk("f_top_addr", {32'h0, bus.imem_req_addr}, 64'hFFFF_FFFC);
      tick();
      chk("f_wrap_addr", {32'h0, bus.imem_req_addr}, 64'h0);

      // reset in the middle of a burst
      lat = 2;
      bus.id_ready = 1'b0;
      do_reset();
      ticks(4);
      rst = 1'b1;
      pend_addr.delete();
      pend_due.delete();
      #1;
      chk("g_rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
      chk("g_rst_id_valid", {63'h0, bus.id_valid}, 64'h0);
      tick();
      rst = 1'b0;
      bus.id_ready = 1'b1;
      req_log.delete();
      got.delete();
      #1;
      chk("g_id_clear", {63'h0, bus.id_valid}, 64'h0);
      chk("g_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      chk("g_req_addr", {32'h0, bus.imem_req_addr}, 64'h0);
      ticks(6);
      chk("g_id0", got_at(0), ent(32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
